// File: rtl/regfile.sv
// Integer register file (x1..x31, x0 hardwired to zero) with a per-register load-pending scoreboard.
// Define RITTER_RF_BYPASS_EN to forward same-cycle writeback data to reads and mask its hazard.
module regfile #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [4:0]      i_rd_addr,
    input  logic [XLEN-1:0] i_rd_data,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    input  logic            i_rs1_used,
    input  logic            i_rs2_used,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    input  logic            i_pend_set,
    input  logic [4:0]      i_pend_addr,
    input  logic            i_flush,
    output logic            o_hazard,
    output logic            o_pend_any
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [NREG-1:1] pend_q;
    logic [NREG-1:1] pend_d;

    logic [XLEN-1:0] rs1_stored;
    logic [XLEN-1:0] rs2_stored;
    logic            rs1_pend;
    logic            rs2_pend;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (i_rd_addr == 5'(i)) begin
                    regs_q[i] <= i_rd_data;
                end
            end
        end
    end

    // Set beats clear (a newer load replaces the completing one); flush beats both.
    always_comb begin
        pend_d = pend_q;
        for (int i = 1; i < NREG; i++) begin
            if (i_rd_addr == 5'(i)) begin
                pend_d[i] = 1'b0;
            end
            if (i_pend_set && (i_pend_addr == 5'(i))) begin
                pend_d[i] = 1'b1;
            end
        end
        if (i_flush) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rs1_stored = '0;
        rs2_stored = '0;
        rs1_pend   = 1'b0;
        rs2_pend   = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (i_rs1_addr == 5'(i)) begin
                rs1_stored = regs_q[i];
                rs1_pend   = pend_q[i];
            end
            if (i_rs2_addr == 5'(i)) begin
                rs2_stored = regs_q[i];
                rs2_pend   = pend_q[i];
            end
        end
    end

    always_comb begin
        o_rs1_data = rs1_stored;
        o_rs2_data = rs2_stored;
        o_hazard   = (i_rs1_used & rs1_pend) | (i_rs2_used & rs2_pend);
`ifdef RITTER_RF_BYPASS_EN
        if ((i_rs1_addr != 5'd0) && (i_rs1_addr == i_rd_addr)) begin
            o_rs1_data = i_rd_data;
        end
        if ((i_rs2_addr != 5'd0) && (i_rs2_addr == i_rd_addr)) begin
            o_rs2_data = i_rd_data;
        end
        // rd_addr is never 0 on a match here since rsN_pend is already 0 for x0.
        o_hazard = (i_rs1_used & rs1_pend & (i_rd_addr != i_rs1_addr))
                 | (i_rs2_used & rs2_pend & (i_rd_addr != i_rs2_addr));
`endif
    end

    assign o_pend_any = |pend_q;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow RITTER_RF_BYPASS_EN if defined.
module tb_regfile;

`ifdef RITTER_RF_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_used;
    logic        rs2_used;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic        flush;
    logic        hazard;
    logic        pend_any;

    int checks;
    int failures;

    regfile #(.XLEN(32), .NREG(32)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .i_rs1_addr (rs1_addr),
        .i_rs2_addr (rs2_addr),
        .i_rs1_used (rs1_used),
        .i_rs2_used (rs2_used),
        .o_rs1_data (rs1_data),
        .o_rs2_data (rs2_data),
        .i_pend_set (pend_set),
        .i_pend_addr(pend_addr),
        .i_flush    (flush),
        .o_hazard   (hazard),
        .o_pend_any (pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        rd_addr   = '0;
        rd_data   = '0;
        rs1_addr  = '0;
        rs2_addr  = '0;
        rs1_used  = 1'b0;
        rs2_used  = 1'b0;
        pend_set  = 1'b0;
        pend_addr = '0;
        flush     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Populate state, then assert reset mid-cycle with no clock edge
        rd_addr = 5'd5; rd_data = 32'h0000_00AA; pend_set = 1'b1; pend_addr = 5'd31;
        tick();
        rd_addr = 5'd0; pend_set = 1'b0; rs1_addr = 5'd5; rs2_addr = 5'd31;
        rs1_used = 1'b1; rs2_used = 1'b1;
        #1;
        chk("pre_rst_x5", rs1_data, 32'h0000_00AA);
        chk("pre_rst_pend_any", {31'd0, pend_any}, 32'd1);
        chk("pre_rst_hazard", {31'd0, hazard}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_x5", rs1_data, 32'd0);
        chk("rst_x31", rs2_data, 32'd0);
        chk("rst_hazard", {31'd0, hazard}, 32'd0);
        chk("rst_pend_any", {31'd0, pend_any}, 32'd0);
        rst_n = 1'b1; rs1_used = 1'b0; rs2_used = 1'b0;
        tick();

        // Write x7 and observe same-cycle and next-cycle reads
        rd_addr = 5'd7; rd_data = 32'hDEAD_BEEF; rs1_addr = 5'd7;
        #1;
        chk("x7_same_cycle", rs1_data, Byp ? 32'hDEAD_BEEF : 32'd0);
        tick();
        rd_addr = 5'd0; rd_data = '0;
        #1;
        chk("x7_next_cycle", rs1_data, 32'hDEAD_BEEF);

        // x0 immunity for writes and pending set
        rd_addr = 5'd0; rd_data = 32'hFFFF_FFFF; pend_set = 1'b1; pend_addr = 5'd0;
        rs1_addr = 5'd0; rs2_addr = 5'd0; rs1_used = 1'b1; rs2_used = 1'b1;
        tick();
        pend_set = 1'b0; rd_data = '0;
        #1;
        chk("x0_rs1", rs1_data, 32'd0);
        chk("x0_rs2", rs2_data, 32'd0);
        chk("x0_pend_any", {31'd0, pend_any}, 32'd0);
        chk("x0_hazard", {31'd0, hazard}, 32'd0);
        rs1_used = 1'b0; rs2_used = 1'b0;

        // Load hazard on x3
        pend_set = 1'b1; pend_addr = 5'd3;
        #1;
        chk("ld_set_cycle_hazard", {31'd0, hazard}, 32'd0);
        tick();
        pend_set = 1'b0; rs2_addr = 5'd3; rs2_used = 1'b1;
        #1;
        chk("ld_hazard_used", {31'd0, hazard}, 32'd1);
        chk("ld_pend_any", {31'd0, pend_any}, 32'd1);
        rs2_used = 1'b0;
        #1;
        chk("ld_hazard_unused", {31'd0, hazard}, 32'd0);
        rs2_used = 1'b1; rd_addr = 5'd3; rd_data = 32'h0000_0012;
        #1;
        chk("ld_wb_cycle_hazard", {31'd0, hazard}, Byp ? 32'd0 : 32'd1);
        chk("ld_wb_cycle_data", rs2_data, Byp ? 32'h0000_0012 : 32'd0);
        tick();
        rd_addr = 5'd0; rd_data = '0;
        #1;
        chk("ld_after_wb_hazard", {31'd0, hazard}, 32'd0);
        chk("ld_after_wb_data", rs2_data, 32'h0000_0012);
        chk("ld_after_wb_pend_any", {31'd0, pend_any}, 32'd0);
        rs2_used = 1'b0;

        // Simultaneous set and clear of x4: set wins, data still written
        pend_set = 1'b1; pend_addr = 5'd4; rd_addr = 5'd4; rd_data = 32'h0000_0044;
        tick();
        pend_set = 1'b0; rd_addr = 5'd0; rd_data = '0; rs1_addr = 5'd4; rs1_used = 1'b1;
        #1;
        chk("setclr_hazard", {31'd0, hazard}, 32'd1);
        chk("setclr_data", rs1_data, 32'h0000_0044);
        chk("setclr_pend_any", {31'd0, pend_any}, 32'd1);
        rs1_used = 1'b0; rd_addr = 5'd4; rd_data = 32'h0000_0045;
        tick();
        rd_addr = 5'd0; rd_data = '0;
        #1;
        chk("x4_cleared_pend_any", {31'd0, pend_any}, 32'd0);

        // Flush overrides a concurrent set; writeback still lands
        pend_set = 1'b1; pend_addr = 5'd2;
        tick();
        pend_addr = 5'd9;
        tick();
        pend_set = 1'b0; rs1_addr = 5'd9; rs1_used = 1'b1;
        #1;
        chk("pre_flush_hazard_x9", {31'd0, hazard}, 32'd1);
        rs1_used = 1'b0;
        pend_set = 1'b1; pend_addr = 5'd10; flush = 1'b1; rd_addr = 5'd6; rd_data = 32'h0000_0066;
        tick();
        pend_set = 1'b0; flush = 1'b0; rd_addr = 5'd0; rd_data = '0;
        rs1_addr = 5'd2; rs2_addr = 5'd10; rs1_used = 1'b1; rs2_used = 1'b1;
        #1;
        chk("flush_pend_any", {31'd0, pend_any}, 32'd0);
        chk("flush_hazard_x2_x10", {31'd0, hazard}, 32'd0);
        rs1_addr = 5'd9;
        #1;
        chk("flush_hazard_x9", {31'd0, hazard}, 32'd0);
        rs1_used = 1'b0; rs2_used = 1'b0; rs2_addr = 5'd6;
        #1;
        chk("flush_wb_x6", rs2_data, 32'h0000_0066);

        // Both ports on one address, then independent addresses
        rs1_addr = 5'd7; rs2_addr = 5'd7;
        #1;
        chk("dual_rs1_x7", rs1_data, 32'hDEAD_BEEF);
        chk("dual_rs2_x7", rs2_data, 32'hDEAD_BEEF);
        rs2_addr = 5'd4;
        #1;
        chk("indep_rs1_x7", rs1_data, 32'hDEAD_BEEF);
        chk("indep_rs2_x4", rs2_data, 32'h0000_0045);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
